// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer in front of the icache read port.
//
// Owns the PC and keeps at most one icache read outstanding. A redirect
// (jump_en) always wins: a read that is already accepted is marked stale and
// its data is dropped when it completes. A fetched instruction is held on
// out_* until IF/ID accepts it (out_valid=1 and full_stall=0).
//
// Ports:
//   clk, rst           clock (rising edge); asynchronous reset, active-low
//   jump_en/jump_addr  redirect request and target (target is word-aligned here)
//   jump_stall         blocks launching a new fetch
//   full_stall         downstream cannot take the held instruction
//   ic_read_flag       icache read request (registered)
//   ic_addr            icache read address (registered, holds between requests)
//   ic_read_data       icache data, valid with ic_done
//   ic_busy            icache cannot accept a request this cycle
//   ic_done            single-cycle read-complete pulse
//   out_valid          out_inst/out_pc hold a valid instruction
//   out_inst, out_pc   fetched instruction and its PC
//   flush_cnt          saturating count of discarded reads / held instructions
module fetch_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              jump_stall,
  input  logic              full_stall,
  output logic              ic_read_flag,
  output logic [ADDR_W-1:0] ic_addr,
  input  logic [INST_W-1:0] ic_read_data,
  input  logic              ic_busy,
  input  logic              ic_done,
  output logic              out_valid,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,  // waiting to launch a fetch
    S_REQ,   // request presented, waiting for ic_busy=0
    S_WAIT,  // request accepted, waiting for ic_done
    S_DROP,  // accepted request went stale; swallow its ic_done
    S_HOLD   // instruction presented to IF/ID
  } state_t;

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_pc, w_pc_next;
  logic              r_ic_read_flag, w_ic_read_flag_next;
  logic [ADDR_W-1:0] r_ic_addr, w_ic_addr_next;
  logic              r_out_valid, w_out_valid_next;
  logic [INST_W-1:0] r_out_inst, w_out_inst_next;
  logic [ADDR_W-1:0] r_out_pc, w_out_pc_next;
  logic [CNT_W-1:0]  r_flush_cnt, w_flush_cnt_next;

  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_pc_inc;
  logic              w_accept;
  logic              w_handoff;
  logic              w_flush_inc;

  // Masking the low two bits keeps every jump_addr bit in use.
  assign w_target  = jump_addr & ~ADDR_W'(3);
  assign w_pc_inc  = r_pc + ADDR_W'(4);
  assign w_accept  = r_ic_read_flag & ~ic_busy;
  assign w_handoff = r_out_valid & ~full_stall;

  always_comb begin
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_out_valid_next = r_out_valid;
    w_out_inst_next  = r_out_inst;
    w_out_pc_next    = r_out_pc;
    w_flush_inc      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (jump_en) begin
          w_pc_next = w_target;
        end else if (!jump_stall && !full_stall) begin
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (jump_en) begin
          w_pc_next = w_target;
          if (w_accept) begin
            // The icache took the old address; its data must be thrown away.
            w_state_next = S_DROP;
            w_flush_inc  = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end else if (w_accept) begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (jump_en) begin
          w_pc_next    = w_target;
          w_flush_inc  = 1'b1;
          w_state_next = ic_done ? S_IDLE : S_DROP;
        end else if (ic_done) begin
          w_out_inst_next  = ic_read_data;
          w_out_pc_next    = r_pc;
          w_out_valid_next = 1'b1;
          w_pc_next        = w_pc_inc;
          w_state_next     = S_HOLD;
        end
      end
      S_DROP: begin
        if (jump_en) begin
          w_pc_next = w_target;
        end
        if (ic_done) begin
          w_state_next = S_IDLE;
        end
      end
      S_HOLD: begin
        if (jump_en) begin
          w_out_valid_next = 1'b0;
          w_pc_next        = w_target;
          w_state_next     = S_IDLE;
          // Only a held instruction that IF/ID did not take counts as flushed.
          w_flush_inc      = ~w_handoff;
        end else if (!full_stall) begin
          w_out_valid_next = 1'b0;
          w_state_next     = jump_stall ? S_IDLE : S_REQ;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Request outputs are registered from the next state so they line up
    // exactly with the REQ state.
    w_ic_read_flag_next = (w_state_next == S_REQ);
    w_ic_addr_next      = (w_state_next == S_REQ) ? w_pc_next : r_ic_addr;

    if (w_flush_inc && (r_flush_cnt != {CNT_W{1'b1}})) begin
      w_flush_cnt_next = r_flush_cnt + CNT_W'(1);
    end else begin
      w_flush_cnt_next = r_flush_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_pc           <= RESET_PC;
      r_ic_read_flag <= 1'b0;
      r_ic_addr      <= '0;
      r_out_valid    <= 1'b0;
      r_out_inst     <= '0;
      r_out_pc       <= '0;
      r_flush_cnt    <= '0;
    end else begin
      r_state        <= w_state_next;
      r_pc           <= w_pc_next;
      r_ic_read_flag <= w_ic_read_flag_next;
      r_ic_addr      <= w_ic_addr_next;
      r_out_valid    <= w_out_valid_next;
      r_out_inst     <= w_out_inst_next;
      r_out_pc       <= w_out_pc_next;
      r_flush_cnt    <= w_flush_cnt_next;
    end
  end

  assign ic_read_flag = r_ic_read_flag;
  assign ic_addr      = r_ic_addr;
  assign out_valid    = r_out_valid;
  assign out_inst     = r_out_inst;
  assign out_pc       = r_out_pc;
  assign flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized scoreboard bench for fetch_ctrl.
// The driver plays EX/IF-ID/icache with $urandom and keeps a transaction-level
// reference model (expected PC, outstanding read, stale flag, held item,
// flush count). Completed non-stale reads push the expected handoff into a
// queue; the monitor pops and compares on every DUT handoff.
module tb_fetch_ctrl;
  localparam int             AW   = 32;
  localparam int             IW   = 32;
  localparam int             CW   = 3;
  localparam logic [AW-1:0]  RPC  = 32'h0000_0080;
  localparam int             MAXF = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          jump_en = 1'b0;
  logic [AW-1:0] jump_addr = '0;
  logic          jump_stall = 1'b0;
  logic          full_stall = 1'b0;
  logic          ic_read_flag;
  logic [AW-1:0] ic_addr;
  logic [IW-1:0] ic_read_data = '0;
  logic          ic_busy = 1'b0;
  logic          ic_done = 1'b0;
  logic          out_valid;
  logic [IW-1:0] out_inst;
  logic [AW-1:0] out_pc;
  logic [CW-1:0] flush_cnt;

  fetch_ctrl #(
    .ADDR_W  (AW),
    .INST_W  (IW),
    .RESET_PC(RPC),
    .CNT_W   (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .jump_stall  (jump_stall),
    .full_stall  (full_stall),
    .ic_read_flag(ic_read_flag),
    .ic_addr     (ic_addr),
    .ic_read_data(ic_read_data),
    .ic_busy     (ic_busy),
    .ic_done     (ic_done),
    .out_valid   (out_valid),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;
  } item_t;

  item_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    handoffs = 0;

  // Reference model state
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_if_addr;
  bit            m_inflight, m_stale, m_held, m_held_next, m_held_vis;
  int            m_dly, m_flush, m_flush_vis;
  bit            prev_jump;

  function automatic logic [IW-1:0] mem(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_pc = RPC; m_if_addr = '0;
    m_inflight = 0; m_stale = 0; m_held = 0; m_held_next = 0; m_held_vis = 0;
    m_dly = 0; m_flush = 0; m_flush_vis = 0; prev_jump = 0;
    exp_q.delete();
  endtask

  // One clock cycle of stimulus plus model update for that cycle.
  task automatic drive_cycle(input bit force_done);
    bit            acc, jmp, done, ho;
    logic [AW-1:0] ja, pc_before;
    item_t         it;
    @(posedge clk); #1;
    if (m_held_next) m_held = 1;
    m_held_next = 0;
    m_flush_vis = m_flush;
    m_held_vis  = m_held;

    jmp        = !prev_jump && ($urandom_range(0, 99) < 10);
    ja         = $urandom();
    jump_stall = ($urandom_range(0, 99) < 20);
    full_stall = ($urandom_range(0, 99) < 35);
    ic_busy    = ($urandom_range(0, 99) < 30);
    done = 0;
    if (m_inflight) begin
      if (m_dly <= 1) done = 1;
      else m_dly--;
    end else if (force_done || $urandom_range(0, 99) < 5) begin
      done = 1;  // stray completion, must be ignored
    end
    ic_done      = done;
    ic_read_data = (done && m_inflight) ? mem(m_if_addr) : $urandom();
    jump_en      = jmp;
    jump_addr    = ja;
    prev_jump    = jmp;

    acc       = ic_read_flag && !ic_busy;
    ho        = m_held && !full_stall;
    pc_before = m_pc;
    if (acc) begin
      chk("accept_addr", ic_addr, m_pc);
      chk("one_outstanding", {m_inflight, m_held}, 0);
    end
    if (done && m_inflight) begin
      m_inflight = 0;
      if (!m_stale) begin
        if (jmp) m_flush++;
        else begin
          it.pc = m_if_addr; it.inst = mem(m_if_addr);
          exp_q.push_back(it);
          m_held_next = 1;
          m_pc = m_if_addr + 4;
        end
      end
    end
    if (jmp) begin
      if (m_inflight && !m_stale) begin m_stale = 1; m_flush++; end
      if (acc) m_flush++;
      if (m_held && full_stall) begin
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        m_held = 0;
        m_flush++;
      end
      m_pc = {ja[AW-1:2], 2'b00};
    end
    if (acc) begin
      m_inflight = 1; m_stale = jmp; m_if_addr = pc_before;
      m_dly = $urandom_range(1, 4);
    end
    if (ho) m_held = 0;
    if (m_flush > MAXF) m_flush = MAXF;
  endtask

  task automatic mid_reset();
    @(posedge clk); #1;
    rst = 0;
    m_reset();
    jump_en = 0; ic_done = 1; ic_read_data = $urandom();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      ic_done = (k % 2 == 1);
      ic_busy = $urandom_range(0, 1);
    end
    // Release with a stray ic_done in the first cycle out of reset.
    @(posedge clk); #1;
    rst = 1; ic_done = 1; jump_en = 0; jump_stall = 0; full_stall = 0; ic_busy = 0;
  endtask

  // Monitor: samples mid-cycle, compares against the scoreboard and model.
  item_t         mon_it;
  logic          p_rf, p_busy, p_ov, p_fs, p_js, p_je;
  logic [AW-1:0] p_addr, p_opc;
  logic [IW-1:0] p_inst;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_ic", {ic_read_flag, ic_addr}, 0);
        chk("rst_out", {out_valid, out_pc}, 0);
        chk("rst_inst_cnt", {flush_cnt, out_inst}, 0);
        p_rf = 0; p_busy = 0; p_ov = 0; p_fs = 0; p_js = 0; p_je = 0;
        p_addr = '0; p_opc = '0; p_inst = '0;
      end else begin
        chk("out_valid", out_valid, m_held_vis);
        chk("flush_cnt", flush_cnt, m_flush_vis);
        if (p_ov && p_fs && !p_je) begin
          chk("stall_pc", out_pc, p_opc);
          chk("stall_inst", out_inst, p_inst);
          chk("stall_no_req", ic_read_flag, 0);
        end
        if (out_valid && !full_stall) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL handoff: got pc 0x%0h with empty scoreboard, required none", out_pc);
          end else begin
            mon_it = exp_q.pop_front();
            chk("handoff_pc", out_pc, mon_it.pc);
            chk("handoff_inst", out_inst, mon_it.inst);
            handoffs++;
          end
        end
        if (ic_read_flag && !p_rf) chk("issue_gate", {p_je, p_js, p_fs}, 0);
        if (p_rf && !p_busy) chk("drop_after_accept", ic_read_flag, 0);
        if (p_rf && p_busy && !p_je) begin
          chk("busy_hold_flag", ic_read_flag, 1);
          chk("busy_hold_addr", ic_addr, p_addr);
        end
        if (p_rf && p_busy && p_je) chk("busy_jump_cancel", ic_read_flag, 0);
        p_rf = ic_read_flag; p_busy = ic_busy; p_ov = out_valid; p_fs = full_stall;
        p_js = jump_stall; p_je = jump_en; p_addr = ic_addr; p_opc = out_pc; p_inst = out_inst;
      end
    end
  end

  initial begin
    int w;
    m_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1;
    for (int i = 0; i < 3000; i++) drive_cycle(0);

    // Reset while a live read is outstanding (DUT in WAIT at the next edge).
    w = 0;
    while (!(m_inflight && !m_stale) && w < 500) begin
      drive_cycle(0);
      w++;
    end
    if (w >= 500) begin
      checks++; failures++;
      $display("FAIL wait_for_fetch: got no outstanding read in %0d cycles, required one", w);
    end
    mid_reset();
    drive_cycle(1);
    for (int i = 0; i < 2000; i++) drive_cycle(0);

    @(posedge clk); #2;
    chk("progress", (handoffs >= 100), 1);
    chk("sb_residual", (exp_q.size() <= 1), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencing controller for the instruction-cache read port in the fetch stage. It owns the PC and issues one icache read at a time. It handles the icache busy/done handshake, redirects on jumps, and discards stale in-flight reads. It holds the fetched instruction toward IF/ID while the pipeline is stalled. It replaces ad-hoc combinational fetch logic with a registered state machine.

Parameters:
ADDR_W, 32, width of PC and icache address
INST_W, 32, width of instruction word
RESET_PC, 0, PC loaded on reset (word-aligned)
CNT_W, 16, width of the saturating flush counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
jump_en  in  1  redirect request from EX, single-cycle
jump_addr  in  ADDR_W  redirect target, valid with jump_en
jump_stall  in  1  branch/jump pending in ID/EX; blocks new issue
full_stall  in  1  downstream cannot accept an instruction
ic_read_flag  out  1  icache read request
ic_addr  out  ADDR_W  icache read address
ic_read_data  in  INST_W  icache data, valid when ic_done=1
ic_busy  in  1  icache cannot accept a request / miss in progress
ic_done  in  1  single-cycle read-complete pulse
out_valid  out  1  out_inst/out_pc hold a valid instruction
out_inst  out  INST_W  fetched instruction to IF/ID
out_pc  out  ADDR_W  PC of out_inst
flush_cnt  out  CNT_W  count of discarded reads and held instructions, saturating

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, state=IDLE, flush_cnt=0.
  - ic_read_flag=0, ic_addr=0, out_valid=0, out_inst=0, out_pc=0.
- Reset mid-operation aborts everything. A later ic_done for a pre-reset request is ignored because state is IDLE.
- Icache handshake:
  - A request is accepted in a cycle where ic_read_flag=1 and ic_busy=0.
  - Exactly one outstanding request at a time.
  - ic_done arrives one or more cycles after acceptance.
  - ic_done outside WAIT/DROP is ignored.
- ic_read_flag and ic_addr are registered outputs. ic_addr=pc while in REQ, otherwise it holds its last value.
- Handoff: IF/ID captures out_inst/out_pc in a cycle with out_valid=1 and full_stall=0.
- Jump target alignment: pc <= {jump_addr[ADDR_W-1:2], 2'b00}.
- Sequential increment: pc+4 wraps modulo 2^ADDR_W.
- States and transitions (jump_en has highest priority in every state):
  - IDLE:
    - jump_en: pc<=target, stay IDLE.
    - Otherwise if !jump_stall && !full_stall: go REQ.
  - REQ (ic_read_flag=1):
    - jump_en with request not accepted (ic_busy=1): pc<=target, drop request, go IDLE.
    - jump_en with request accepted: pc<=target, go DROP, flush_cnt++.
    - Otherwise accepted: go WAIT; not accepted: stay REQ.
  - WAIT:
    - jump_en: pc<=target. If ic_done in the same cycle, discard the data and go IDLE; otherwise go DROP. flush_cnt++ in either case.
    - Otherwise on ic_done: out_inst<=ic_read_data, out_pc<=pc, out_valid<=1, pc<=pc+4, go HOLD.
  - DROP:
    - jump_en updates pc again.
    - On ic_done: discard the data, go IDLE.
  - HOLD (out_valid=1):
    - jump_en: out_valid<=0, pc<=target, go IDLE. If no handoff occurs that cycle, flush_cnt++.
    - Else if full_stall: hold all outputs unchanged.
    - Else (handoff): out_valid<=0. Go REQ if !jump_stall, else IDLE.
- jump_stall blocks only new issue (IDLE->REQ, HOLD->REQ). It does not cancel REQ/WAIT or block a handoff.
- Latency: with request accepted at cycle t and ic_done at t+k, out_valid=1 at t+k+1. Earliest next ic_read_flag=1 is at t+k+2.
- flush_cnt saturates at all-ones. It does not wrap.

Test Plan:
1. Reset release, icache done 2 cycles after accept, no stalls → ic_addr 0x0, 0x4, 0x8 in sequence. out_pc 0x0/0x4/0x8 with matching data. out_valid pulses 1 cycle each, 4-cycle period.
2. full_stall held 5 cycles while in HOLD with out_pc=0x4 → out_valid, out_inst, out_pc stable for all 5 cycles and no new ic_read_flag. After release, next request has ic_addr=0x8.
3. jump_en with jump_addr=0x103 during WAIT for pc=0x8 → ic_done data for 0x8 never appears on out_inst. Next request has ic_addr=0x100. flush_cnt=1.
4. ic_busy=1 for 3 cycles while in REQ → ic_read_flag stays 1 with constant ic_addr, and exactly one accept occurs. jump_en during busy → return to IDLE with flush_cnt unchanged, next ic_addr=jump target.
5. jump_stall=1 immediately after a handoff → no ic_read_flag while stall is high. Release with simultaneous jump_en to 0x40 → next ic_addr=0x40.
6. rst asserted in WAIT, with ic_done pulsing during reset and one cycle after release → all outputs 0, out_valid stays 0, first request has ic_addr=RESET_PC.
